// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status control for a DEPTH-entry register-file FIFO.
// Strobes and addresses are combinational; the ack/err status is a Moore decode of a
// small FSM, so each request's status appears one cycle after the request.
module fifo_ctrl #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          we,
  output logic [AW-1:0] wAddr,
  output logic          re,
  output logic [AW-1:0] rAddr,
  output logic [CW-1:0] data_count,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    WRITE  = 3'b001,
    READ   = 3'b010,
    WRRD   = 3'b011,
    WR_ERR = 3'b100,
    RD_ERR = 3'b101
  } state_t;

  state_t        state, state_nxt;
  logic          opp, opp_nxt;   // opposite op completed alongside a rejected one
  logic [AW-1:0] head, tail;

  // Occupancy flags come from the count only; pointers are equal at both full and empty.
  assign full  = (data_count == CW'(DEPTH));
  assign empty = (data_count == '0);

  // Strobes are gated off during reset so no write/read reaches the storage.
  assign we    = wr_en & ~full  & ~reset;
  assign re    = rd_en & ~empty & ~reset;
  assign wAddr = tail;
  assign rAddr = head;

  // Pointers wrap naturally at 2**AW; occupancy tracks net writes minus reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      if (we) tail <= tail + 1'b1;
      if (re) head <= head + 1'b1;
      if (we && !re)      data_count <= data_count + 1'b1;
      else if (re && !we) data_count <= data_count - 1'b1;
    end
  end

  // Status FSM state and the opposite-op qualifier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      opp   <= 1'b0;
    end else begin
      state <= state_nxt;
      opp   <= opp_nxt;
    end
  end

  // Next state by request priority; outputs decoded from the current state.
  always_comb begin
    state_nxt = IDLE;
    opp_nxt   = 1'b0;
    if (we && re) begin
      state_nxt = WRRD;
    end else if (wr_en && full) begin
      state_nxt = WR_ERR;
      opp_nxt   = re;
    end else if (rd_en && empty) begin
      state_nxt = RD_ERR;
      opp_nxt   = we;
    end else if (we) begin
      state_nxt = WRITE;
    end else if (re) begin
      state_nxt = READ;
    end

    wr_ack = (state == WRITE) || (state == WRRD) || ((state == RD_ERR) && opp);
    rd_ack = (state == READ)  || (state == WRRD) || ((state == WR_ERR) && opp);
    wr_err = (state == WR_ERR);
    rd_err = (state == RD_ERR);
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: reset, fill/overflow, full and empty corner cases with
// simultaneous requests, steady-state write+read, and an asynchronous mid-cycle reset.
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset, wr_en, rd_en;
  logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [4:0] wAddr, rAddr;
  logic [5:0] data_count;
  int         n_run = 0, n_fail = 0;

  fifo_ctrl #(.DEPTH(32)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .we(we), .wAddr(wAddr), .re(re), .rAddr(rAddr),
    .data_count(data_count), .full(full), .empty(empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r);
    wr_en = w;
    rd_en = r;
    #1;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    #12;
    // reset state, strobes forced low even with requests present
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_cnt", data_count, 0);
    chk("rst_we", we, 0); chk("rst_re", re, 0); chk("rst_wa", wAddr, 0); chk("rst_ra", rAddr, 0);
    chk("rst_acks", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    drive(0, 0);
    reset = 1'b0;

    // read at empty is rejected
    drive(0, 1);
    chk("rde_re", re, 0);
    tick();
    chk("rde_err", rd_err, 1); chk("rde_ack", rd_ack, 0);
    chk("rde_ra", rAddr, 0); chk("rde_cnt", data_count, 0);

    // first write
    drive(1, 0);
    chk("w1_we", we, 1); chk("w1_wa", wAddr, 0);
    tick();
    chk("w1_cnt", data_count, 1); chk("w1_empty", empty, 0); chk("w1_ack", wr_ack, 1);
    chk("w1_rderr", rd_err, 0);

    // fill to 32
    for (int i = 0; i < 31; i++) tick();
    chk("fill_cnt", data_count, 32); chk("fill_full", full, 1); chk("fill_wa", wAddr, 0);

    // overflow attempt
    chk("ovf_we", we, 0);
    tick();
    chk("ovf_err", wr_err, 1); chk("ovf_ack", wr_ack, 0);
    chk("ovf_cnt", data_count, 32); chk("ovf_wa", wAddr, 0);

    // both at full: read only
    drive(1, 1);
    chk("fb_we", we, 0); chk("fb_re", re, 1);
    tick();
    chk("fb_state", dut.state, 3'b100); chk("fb_rdack", rd_ack, 1); chk("fb_wrerr", wr_err, 1);
    chk("fb_wrack", wr_ack, 0); chk("fb_cnt", data_count, 31);
    chk("fb_ra", rAddr, 1); chk("fb_wa", wAddr, 0);

    // drain to 5
    drive(0, 1);
    for (int i = 0; i < 26; i++) tick();
    chk("dr_cnt", data_count, 5); chk("dr_ra", rAddr, 27); chk("dr_rdack", rd_ack, 1);

    // three simultaneous write+read cycles at count 5
    drive(1, 1);
    for (int i = 0; i < 3; i++) begin
      chk("wr3_we", we, 1); chk("wr3_re", re, 1);
      tick();
    end
    chk("wr3_cnt", data_count, 5); chk("wr3_ra", rAddr, 30); chk("wr3_wa", wAddr, 3);
    chk("wr3_acks", {wr_ack, rd_ack, wr_err, rd_err}, 4'b1100);

    // drain to empty (head wraps 31->0)
    drive(0, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("de_cnt", data_count, 0); chk("de_empty", empty, 1); chk("de_ra", rAddr, 3);

    // both at empty: write only
    drive(1, 1);
    chk("eb_we", we, 1); chk("eb_re", re, 0);
    tick();
    chk("eb_state", dut.state, 3'b101); chk("eb_wrack", wr_ack, 1); chk("eb_rderr", rd_err, 1);
    chk("eb_rdack", rd_ack, 0); chk("eb_cnt", data_count, 1);
    chk("eb_wa", wAddr, 4); chk("eb_ra", rAddr, 3);

    // idle cycle clears status
    drive(0, 0);
    tick();
    chk("idle_acks", {wr_ack, wr_err, rd_ack, rd_err}, 0); chk("idle_cnt", data_count, 1);

    // write up to 17, then async reset mid-cycle
    drive(1, 0);
    for (int i = 0; i < 16; i++) tick();
    chk("pre_cnt", data_count, 17); chk("pre_ack", wr_ack, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_cnt", data_count, 0); chk("ar_empty", empty, 1); chk("ar_full", full, 0);
    chk("ar_wa", wAddr, 0); chk("ar_ra", rAddr, 0); chk("ar_we", we, 0);
    chk("ar_acks", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    @(negedge clk);
    reset = 1'b0;

    // first edge after reset behaves as empty
    drive(1, 1);
    tick();
    chk("post_cnt", data_count, 1); chk("post_rderr", rd_err, 1); chk("post_wrack", wr_ack, 1);
    drive(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
